// File: rtl/password_checker_pkg.sv
// Shared definitions for the password checker slice.
//   - keypad code constants (clear key, digit range)
//   - FSM state encoding
//   - is_digit helper used to classify incoming key codes
package password_checker_pkg;

    localparam int unsigned KEY_CLEAR     = 12;  // 4'hC
    localparam int unsigned KEY_DIGIT_MAX = 9;   // digits are 0..9

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StCheck   = 3'd2,
        StResOk   = 3'd3,
        StResErr  = 3'd4,
        StLock    = 3'd5
    } state_e;

    function automatic logic is_digit(input int unsigned code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/password_timer.sv
// Inter-key idle timer.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   load    in  restart count from zero (an accepted key)
//   enable  in  count while an attempt is being collected
//   expire  out count has reached TIMEOUT_CYC-1
module password_timer
    import password_checker_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt_q <= '0;
        end else if (enable && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Depends on the register only, so the FSM can read it without a comb loop.
    assign expire = (cnt_q == CntMax);

endmodule

// File: rtl/password_checker.sv
// Password handshake responder for the parking access controller.
// Collects keypad digits while the access FSM requests a password, compares
// them with pasw_ref and reports level ok / erro. Inter-key timeout and a
// consecutive-failure lockout are included.
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   pasw_req   in   password requested (level); low clears everything
//   key_valid  in   one-cycle key strobe
//   key_code   in   0-9 digit, 4'hC clear, other codes ignored
//   pasw_ref   in   stored password, first digit in the MS nibble
//   busy       out  attempt in progress
//   ok         out  password matched (level)
//   erro       out  mismatch / timeout / lockout (level)
//   locked     out  MAX_TRIES consecutive failures reached
//   digit_cnt  out  digits held in the current attempt
module password_checker
    import password_checker_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned MAX_TRIES   = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pasw_req,
    input  logic                            key_valid,
    input  logic [DIGIT_W-1:0]              key_code,
    input  logic [N_DIGITS*DIGIT_W-1:0]     pasw_ref,
    output logic                            busy,
    output logic                            ok,
    output logic                            erro,
    output logic                            locked,
    output logic [$clog2(N_DIGITS+1)-1:0]   digit_cnt
);

    localparam int unsigned PwW = N_DIGITS * DIGIT_W;
    localparam int unsigned CW  = $clog2(N_DIGITS + 1);
    localparam int unsigned FW  = $clog2(MAX_TRIES + 1);

    state_e          state_q, state_d;
    logic [PwW-1:0]  sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [FW-1:0]   fail_inc;
    logic            busy_q, ok_q, erro_q, locked_q;

    logic key_digit, key_clear;
    logic timer_load, timer_en, timer_expire;

    assign key_digit = key_valid && is_digit(32'(key_code));
    assign key_clear = key_valid && (32'(key_code) == KEY_CLEAR);
    assign fail_inc  = fail_q + 1'b1;
    assign timer_en  = (state_q == StCollect);

    password_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .enable (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        timer_load = 1'b0;

        if (!pasw_req) begin
            // Dropping the request wins over any key on the same edge.
            state_d = StIdle;
            sr_d    = '0;
            cnt_d   = '0;
            fail_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StResErr: begin
                    // First digit of a new attempt or a retry; clear key ignored here.
                    if (key_digit) begin
                        sr_d       = PwW'(key_code);
                        cnt_d      = CW'(1);
                        timer_load = 1'b1;
                        state_d    = StCollect;
                    end
                end
                StCollect: begin
                    if (key_digit) begin
                        sr_d       = {sr_q[PwW-DIGIT_W-1:0], key_code};
                        timer_load = 1'b1;
                        if (cnt_q < CW'(N_DIGITS)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (cnt_q == CW'(N_DIGITS - 1)) begin
                            state_d = StCheck;
                        end
                    end else if (key_clear) begin
                        sr_d       = '0;
                        cnt_d      = '0;
                        timer_load = 1'b1;
                    end else if (timer_expire) begin
                        fail_d  = fail_inc;
                        state_d = (fail_inc == FW'(MAX_TRIES)) ? StLock : StResErr;
                    end
                end
                StCheck: begin
                    // Keys arriving here are dropped.
                    if (sr_q == pasw_ref) begin
                        fail_d  = '0;
                        state_d = StResOk;
                    end else begin
                        fail_d  = fail_inc;
                        state_d = (fail_inc == FW'(MAX_TRIES)) ? StLock : StResErr;
                    end
                end
                StResOk, StLock: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sr_q     <= '0;
            cnt_q    <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            ok_q     <= 1'b0;
            erro_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            // Outputs are decoded from the next state so they align with it.
            busy_q   <= (state_d == StCollect) || (state_d == StCheck);
            ok_q     <= (state_d == StResOk);
            erro_q   <= (state_d == StResErr) || (state_d == StLock);
            locked_q <= (state_d == StLock);
        end
    end

    assign busy      = busy_q;
    assign ok        = ok_q;
    assign erro      = erro_q;
    assign locked    = locked_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_password_checker.sv
module tb_password_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        pasw_req;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] pasw_ref;
    logic        busy, ok, erro, locked;
    logic [2:0]  digit_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    password_checker #(
        .N_DIGITS    (4),
        .DIGIT_W     (4),
        .TIMEOUT_CYC (20),
        .MAX_TRIES   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pasw_req  (pasw_req),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pasw_ref  (pasw_ref),
        .busy      (busy),
        .ok        (ok),
        .erro      (erro),
        .locked    (locked),
        .digit_cnt (digit_cnt)
    );

    // {busy, ok, erro, locked, digit_cnt}
    function automatic logic [6:0] ev(input logic b, input logic o, input logic e,
                                      input logic l, input logic [2:0] c);
        return {b, o, e, l, c};
    endfunction

    // Key strobe sampled at the next rising edge; returns at the following negedge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic attempt(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
        @(negedge clk);
    endtask

    task automatic drop_req;
        @(negedge clk);
        pasw_req = 1'b0;
        @(negedge clk);
        pasw_req = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; pasw_req = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        pasw_ref = 16'h1234;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 0, 0, 0)) begin
            $display("FAIL reset: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 0, 0, 0, 0));
        end else pass_cnt++;
    endtask

    task automatic test_match;
        drop_req();
        press(4'd1);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(1, 0, 0, 0, 1)) begin
            $display("FAIL match_key1: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(1, 0, 0, 0, 1));
        end else pass_cnt++;
        press(4'd2); press(4'd3); press(4'd4);
        // In CHECK: result not visible yet.
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(1, 0, 0, 0, 4)) begin
            $display("FAIL match_check: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(1, 0, 0, 0, 4));
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 1, 0, 0, 4)) begin
            $display("FAIL match_ok: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 1, 0, 0, 4));
        end else pass_cnt++;
        press(4'd7);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 1, 0, 0, 4)) begin
            $display("FAIL resok_ignores_key: got %b want %b",
                     {busy, ok, erro, locked, digit_cnt}, ev(0, 1, 0, 0, 4));
        end else pass_cnt++;
    endtask

    task automatic test_retry;
        drop_req();
        press(4'd1); press(4'd2); press(4'd3); press(4'd5);
        // Key during CHECK must be dropped, not start a retry.
        key_valid = 1'b1; key_code = 4'd7;
        @(negedge clk);
        key_valid = 1'b0;
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 1, 0, 4)) begin
            $display("FAIL retry_erro: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 0, 1, 0, 4));
        end else pass_cnt++;
        press(4'hC);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 1, 0, 4)) begin
            $display("FAIL reserr_clear_ignored: got %b want %b",
                     {busy, ok, erro, locked, digit_cnt}, ev(0, 0, 1, 0, 4));
        end else pass_cnt++;
        press(4'd1);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(1, 0, 0, 0, 1)) begin
            $display("FAIL retry_key1: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(1, 0, 0, 0, 1));
        end else pass_cnt++;
        press(4'd2); press(4'd3); press(4'd4);
        @(negedge clk);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 1, 0, 0, 4)) begin
            $display("FAIL retry_ok: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 1, 0, 0, 4));
        end else pass_cnt++;
    endtask

    task automatic test_lockout;
        drop_req();
        attempt(4'd1, 4'd2, 4'd3, 4'd5);
        attempt(4'd9, 4'd9, 4'd9, 4'd9);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 1, 0, 4)) begin
            $display("FAIL lock_second: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 0, 1, 0, 4));
        end else pass_cnt++;
        attempt(4'd4, 4'd3, 4'd2, 4'd1);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 1, 1, 4)) begin
            $display("FAIL lock_third: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 0, 1, 1, 4));
        end else pass_cnt++;
        attempt(4'd1, 4'd2, 4'd3, 4'd4);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 1, 1, 4)) begin
            $display("FAIL lock_ignores_keys: got %b want %b",
                     {busy, ok, erro, locked, digit_cnt}, ev(0, 0, 1, 1, 4));
        end else pass_cnt++;
        @(negedge clk);
        pasw_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 0, 0, 0)) begin
            $display("FAIL lock_release: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 0, 0, 0, 0));
        end else pass_cnt++;
        pasw_req = 1'b1;
    endtask

    task automatic test_clear;
        logic [3:0] keys [7];
        logic [2:0] cnts [7];
        keys = '{4'd9, 4'd8, 4'hC, 4'd1, 4'd2, 4'd3, 4'd4};
        cnts = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        drop_req();
        for (int i = 0; i < 7; i++) begin
            press(keys[i]);
            total_cnt++;
            if (digit_cnt !== cnts[i]) begin
                $display("FAIL clear_cnt[%0d]: got %0d want %0d", i, digit_cnt, cnts[i]);
            end else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 1, 0, 0, 4)) begin
            $display("FAIL clear_ok: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 1, 0, 0, 4));
        end else pass_cnt++;
    endtask

    task automatic test_timeout;
        drop_req();
        press(4'hA);  // non-digit in IDLE: ignored
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 0, 0, 0)) begin
            $display("FAIL idle_ignores_nondigit: got %b want %b",
                     {busy, ok, erro, locked, digit_cnt}, ev(0, 0, 0, 0, 0));
        end else pass_cnt++;
        press(4'd1);
        repeat (19) @(negedge clk);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(1, 0, 0, 0, 1)) begin
            $display("FAIL timeout_early: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(1, 0, 0, 0, 1));
        end else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, ok, erro, locked} !== 4'b0010) begin
            $display("FAIL timeout_erro: got %b want %b", {busy, ok, erro, locked}, 4'b0010);
        end else pass_cnt++;
        // Timeout counted as one failure: two more failures lock.
        attempt(4'd5, 4'd5, 4'd5, 4'd5);
        total_cnt++;
        if ({ok, erro, locked} !== 3'b010) begin
            $display("FAIL timeout_fail2: got %b want %b", {ok, erro, locked}, 3'b010);
        end else pass_cnt++;
        attempt(4'd5, 4'd5, 4'd5, 4'd5);
        total_cnt++;
        if ({ok, erro, locked} !== 3'b011) begin
            $display("FAIL timeout_fail3: got %b want %b", {ok, erro, locked}, 3'b011);
        end else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        drop_req();
        press(4'd1); press(4'd2);
        total_cnt++;
        if ({busy, digit_cnt} !== 4'b1010) begin
            $display("FAIL midrst_pre: got %b want %b", {busy, digit_cnt}, 4'b1010);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 0, 0, 0)) begin
            $display("FAIL midrst_clear: got %b want %b", {busy, ok, erro, locked, digit_cnt},
                     ev(0, 0, 0, 0, 0));
        end else pass_cnt++;
        pasw_req = 1'b0; key_valid = 1'b1; key_code = 4'd1;
        @(negedge clk);
        key_valid = 1'b0;
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 0, 0, 0, 0)) begin
            $display("FAIL req_low_priority: got %b want %b",
                     {busy, ok, erro, locked, digit_cnt}, ev(0, 0, 0, 0, 0));
        end else pass_cnt++;
        pasw_req = 1'b1;
        attempt(4'd1, 4'd2, 4'd3, 4'd4);
        total_cnt++;
        if ({busy, ok, erro, locked, digit_cnt} !== ev(0, 1, 0, 0, 4)) begin
            $display("FAIL midrst_fresh_ok: got %b want %b",
                     {busy, ok, erro, locked, digit_cnt}, ev(0, 1, 0, 0, 4));
        end else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_match();
        test_retry();
        test_lockout();
        test_clear();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
